// File: rtl/player_keys_pkg.sv
// Shared scancode constants, decoder state and key-index types for the player keyboard front end.
package player_keys_pkg;

  localparam logic [7:0] ScPrefixExt = 8'hE0;
  localparam logic [7:0] ScPrefixBrk = 8'hF0;

  localparam logic [7:0] ScLeft  = 8'h6B;
  localparam logic [7:0] ScRight = 8'h74;
  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScFire  = 8'h29;

  localparam logic [7:0] ScWasdLeft  = 8'h1C;
  localparam logic [7:0] ScWasdRight = 8'h23;
  localparam logic [7:0] ScWasdUp    = 8'h1D;
  localparam logic [7:0] ScWasdDown  = 8'h1B;

  typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} seq_state_e;

  typedef enum logic [2:0] {KeyLeft, KeyRight, KeyUp, KeyDown, KeyFire} key_idx_e;

  localparam int unsigned NumKeys = 5;

endpackage

// File: rtl/ps2_seq_decoder.sv
// PS/2 make/break/extended sequence decoder with a prefix timeout; emits one strobe per
// completed sequence (combinational, in the cycle of the final byte).
module ps2_seq_decoder
  import player_keys_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 2_000_000,
  parameter int unsigned TO_WIDTH       = $clog2(PREFIX_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       seq_error
);

  seq_state_e          state_q, state_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    key_valid = 1'b0;
    key_ext   = 1'b0;
    key_break = 1'b0;
    key_code  = rx_data;
    if (rx_valid) begin
      // A byte always beats an expiring timeout; every prefix restarts the gap count.
      cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (rx_data == ScPrefixExt)      state_d = StExt;
          else if (rx_data == ScPrefixBrk) state_d = StBrk;
          else                             key_valid = 1'b1;
        end
        StExt: begin
          if (rx_data == ScPrefixBrk)      state_d = StExtBrk;
          else if (rx_data != ScPrefixExt) begin
            key_valid = 1'b1;
            key_ext   = 1'b1;
            state_d   = StIdle;
          end
        end
        StBrk: begin
          if (rx_data == ScPrefixExt)      state_d = StExtBrk;
          else if (rx_data != ScPrefixBrk) begin
            key_valid = 1'b1;
            key_break = 1'b1;
            state_d   = StIdle;
          end
        end
        StExtBrk: begin
          if (rx_data != ScPrefixExt && rx_data != ScPrefixBrk) begin
            key_valid = 1'b1;
            key_ext   = 1'b1;
            key_break = 1'b1;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (cnt_q == TO_WIDTH'(PREFIX_TIMEOUT)) begin
        state_d = StIdle;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign seq_error = err_q;

endmodule

// File: rtl/player_keys.sv
// Keyboard front end: held level per game key plus a fire edge pulse.
// Optional WASD mapping enabled by defining PLAYER_KEYS_WASD_EN.
module player_keys
  import player_keys_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 2_000_000,
  parameter int unsigned TO_WIDTH       = $clog2(PREFIX_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       move_left,
  output logic       move_right,
  output logic       move_up,
  output logic       move_down,
  output logic       fire_held,
  output logic       fire_pulse,
  output logic       seq_error
);

  logic       key_valid, key_ext, key_break;
  logic [7:0] key_code;

  ps2_seq_decoder #(
    .PREFIX_TIMEOUT(PREFIX_TIMEOUT),
    .TO_WIDTH      (TO_WIDTH)
  ) u_dec (
    .clk      (clk),
    .resetN   (resetN),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ext  (key_ext),
    .key_break(key_break),
    .seq_error(seq_error)
  );

  logic [NumKeys-1:0] held_q, held_d;
  logic               pulse_q, pulse_d;

  always_comb begin
    held_d = held_q;
    if (key_valid) begin
      if (key_ext) begin
        case (key_code)
          ScLeft:  held_d[KeyLeft]  = ~key_break;
          ScRight: held_d[KeyRight] = ~key_break;
          ScUp:    held_d[KeyUp]    = ~key_break;
          ScDown:  held_d[KeyDown]  = ~key_break;
          default: ;
        endcase
      end else if (key_code == ScFire) begin
        held_d[KeyFire] = ~key_break;
      end
    end
    // Typematic repeats keep the bit at 1, so only a real 0->1 edge pulses.
    pulse_d = held_d[KeyFire] & ~held_q[KeyFire];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      held_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef PLAYER_KEYS_WASD_EN
  logic [3:0] wasd_q, wasd_d;

  always_comb begin
    wasd_d = wasd_q;
    if (key_valid && !key_ext) begin
      case (key_code)
        ScWasdLeft:  wasd_d[KeyLeft]  = ~key_break;
        ScWasdRight: wasd_d[KeyRight] = ~key_break;
        ScWasdUp:    wasd_d[KeyUp]    = ~key_break;
        ScWasdDown:  wasd_d[KeyDown]  = ~key_break;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) wasd_q <= '0;
    else         wasd_q <= wasd_d;
  end

  assign move_left  = held_q[KeyLeft]  | wasd_q[KeyLeft];
  assign move_right = held_q[KeyRight] | wasd_q[KeyRight];
  assign move_up    = held_q[KeyUp]    | wasd_q[KeyUp];
  assign move_down  = held_q[KeyDown]  | wasd_q[KeyDown];
`else
  assign move_left  = held_q[KeyLeft];
  assign move_right = held_q[KeyRight];
  assign move_up    = held_q[KeyUp];
  assign move_down  = held_q[KeyDown];
`endif

  assign fire_held  = held_q[KeyFire];
  assign fire_pulse = pulse_q;

endmodule
